// File: rtl/parking_gate_controller.sv
// Parking entry gate: password-checked access with a bounded free-spot counter,
// lockout after repeated wrong passwords, and fully registered outputs.
module parking_gate_controller #(
  parameter int unsigned TOTAL_SPOTS  = 10,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned PASS_W       = 4,
  parameter logic [PASS_W-1:0] PASS_VALUE = PASS_W'(4'b1010),
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned PASS_TIMEOUT = 16,
  parameter int unsigned GATE_CYCLES  = 4,
  parameter int unsigned LOCK_CYCLES  = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_car_request,
  input  logic              i_car_exit,
  input  logic              i_pass_valid,
  input  logic [PASS_W-1:0] i_entered_pass,
  output logic [CNT_W-1:0]  o_available_spots,
  output logic              o_access_granted,
  output logic              o_access_denied,
  output logic              o_gate_open,
  output logic              o_full,
  output logic              o_locked
);

  // One shared timer serves the WAIT_PASS, GRANT and LOCKOUT windows.
  localparam int unsigned TMR_MAX0 = (PASS_TIMEOUT > GATE_CYCLES) ? PASS_TIMEOUT : GATE_CYCLES;
  localparam int unsigned TMR_MAX  = (TMR_MAX0 > LOCK_CYCLES) ? TMR_MAX0 : LOCK_CYCLES;
  localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);
  localparam int unsigned FAIL_W   = $clog2(MAX_TRIES + 1);
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL_SPOTS);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_PASS  = 3'd1,
    ST_CHECK_PASS = 3'd2,
    ST_GRANT      = 3'd3,
    ST_LOCKOUT    = 3'd4
  } state_t;

  state_t              r_state;
  logic [TMR_W-1:0]    r_timer;
  logic [FAIL_W-1:0]   r_fail_cnt;
  logic [PASS_W-1:0]   r_pass;
  logic [CNT_W-1:0]    r_spots;
  logic                r_granted;
  logic                r_denied;
  logic                r_gate;
  logic                r_full;
  logic                r_locked;

  logic                w_match;
  logic                w_dec;
  logic                w_inc;
  logic [CNT_W-1:0]    w_spots_next;
  logic [FAIL_W-1:0]   w_fail_inc;

  // Next spot count: exit and grant cancel out; each side is range-guarded so no wrap.
  always_comb begin
    w_match    = (r_pass == PASS_VALUE);
    w_dec      = (r_state == ST_CHECK_PASS) && w_match && (r_spots != CNT_W'(0));
    w_inc      = i_car_exit && (r_spots < TOTAL_C);
    w_fail_inc = r_fail_cnt + FAIL_W'(1);
    if (w_inc && !w_dec) begin
      w_spots_next = r_spots + CNT_W'(1);
    end else if (w_dec && !w_inc) begin
      w_spots_next = r_spots - CNT_W'(1);
    end else begin
      w_spots_next = r_spots;
    end
  end

  // Gate FSM, spot counter and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_timer    <= TMR_W'(0);
      r_fail_cnt <= FAIL_W'(0);
      r_pass     <= PASS_W'(0);
      r_spots    <= TOTAL_C;
      r_granted  <= 1'b0;
      r_denied   <= 1'b0;
      r_gate     <= 1'b0;
      r_full     <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_spots   <= w_spots_next;
      r_full    <= (w_spots_next == CNT_W'(0));
      r_granted <= 1'b0;
      r_denied  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_car_request) begin
            if (r_spots == CNT_W'(0)) begin
              r_denied <= 1'b1;
            end else begin
              r_state <= ST_WAIT_PASS;
              r_timer <= TMR_W'(0);
            end
          end
        end
        ST_WAIT_PASS: begin
          if (i_pass_valid) begin
            r_pass  <= i_entered_pass;
            r_state <= ST_CHECK_PASS;
          end else if (r_timer == TMR_W'(PASS_TIMEOUT - 1)) begin
            r_denied <= 1'b1;
            r_state  <= ST_IDLE;
            r_timer  <= TMR_W'(0);
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_CHECK_PASS: begin
          r_timer <= TMR_W'(0);
          if (w_dec) begin
            r_granted  <= 1'b1;
            r_gate     <= 1'b1;
            r_fail_cnt <= FAIL_W'(0);
            r_state    <= ST_GRANT;
          end else if (w_match) begin
            // Right password but the lot filled up meanwhile: refuse without penalty.
            r_denied <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_denied   <= 1'b1;
            r_fail_cnt <= w_fail_inc;
            if (w_fail_inc == FAIL_W'(MAX_TRIES)) begin
              r_locked <= 1'b1;
              r_state  <= ST_LOCKOUT;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_GRANT: begin
          if (r_timer == TMR_W'(GATE_CYCLES - 1)) begin
            r_gate  <= 1'b0;
            r_timer <= TMR_W'(0);
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_LOCKOUT: begin
          if (r_timer == TMR_W'(LOCK_CYCLES - 1)) begin
            r_locked   <= 1'b0;
            r_fail_cnt <= FAIL_W'(0);
            r_timer    <= TMR_W'(0);
            r_state    <= ST_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_timer  <= TMR_W'(0);
          r_gate   <= 1'b0;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign o_available_spots = r_spots;
  assign o_access_granted  = r_granted;
  assign o_access_denied   = r_denied;
  assign o_gate_open       = r_gate;
  assign o_full            = r_full;
  assign o_locked          = r_locked;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench: a per-cycle vector table for grant/lockout flow, then
// hand-written sequences for timeout, reset abort, saturation and full lot.
module tb_parking_gate_controller;

  logic       clk;
  logic       reset;
  logic       car_request;
  logic       car_exit;
  logic       pass_valid;
  logic [3:0] entered_pass;
  logic [3:0] available_spots;
  logic       access_granted;
  logic       access_denied;
  logic       gate_open;
  logic       full;
  logic       locked;

  int n_checks = 0;
  int n_errors = 0;
  int exp_spots;

  typedef struct {
    logic       rst, req, ex, pv;
    logic [3:0] pass;
    int         spots;
    logic       g, d, gate, fl, lk;
  } vec_t;

  vec_t tbl[$];

  parking_gate_controller dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_car_request     (car_request),
    .i_car_exit        (car_exit),
    .i_pass_valid      (pass_valid),
    .i_entered_pass    (entered_pass),
    .o_available_spots (available_spots),
    .o_access_granted  (access_granted),
    .o_access_denied   (access_denied),
    .o_gate_open       (gate_open),
    .o_full            (full),
    .o_locked          (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, req, ex, pv, input logic [3:0] pass,
                              input int spots, input logic g, d, gate, fl, lk);
    vec_t v;
    v.rst = rst; v.req = req; v.ex = ex; v.pv = pv; v.pass = pass;
    v.spots = spots; v.g = g; v.d = d; v.gate = gate; v.fl = fl; v.lk = lk;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int spots, input logic g, d, gate, fl, lk);
    chk({tag, ".spots"},   int'(available_spots), spots);
    chk({tag, ".granted"}, int'(access_granted), int'(g));
    chk({tag, ".denied"},  int'(access_denied), int'(d));
    chk({tag, ".gate"},    int'(gate_open), int'(gate));
    chk({tag, ".full"},    int'(full), int'(fl));
    chk({tag, ".locked"},  int'(locked), int'(lk));
  endtask

  task automatic drive(input logic rst, req, ex, pv, input logic [3:0] pass);
    reset = rst; car_request = req; car_exit = ex; pass_valid = pv; entered_pass = pass;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full grant: request, correct password, pulse at third edge, gate open four cycles.
  task automatic do_grant(input string tag, input logic ex_at_check);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    tick();
    chk_all({tag, ".req"}, exp_spots, 1'b0, 1'b0, 1'b0, exp_spots == 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b1010);
    tick();
    chk_all({tag, ".pass"}, exp_spots, 1'b0, 1'b0, 1'b0, exp_spots == 0, 1'b0);
    drive(1'b0, 1'b0, ex_at_check, 1'b0, 4'b0000);
    tick();
    if (!ex_at_check) exp_spots = exp_spots - 1;
    chk_all({tag, ".grant"}, exp_spots, 1'b1, 1'b0, 1'b1, exp_spots == 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all({tag, ".open"}, exp_spots, 1'b0, 1'b0, 1'b1, exp_spots == 0, 1'b0);
    end
    tick();
    chk_all({tag, ".close"}, exp_spots, 1'b0, 1'b0, 1'b0, exp_spots == 0, 1'b0);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);

    // reset, first grant (latency N+3, gate 4 cycles, request ignored in GRANT)
    tbl.push_back(mk(1, 0, 0, 0, 4'b0000, 10, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 10, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 10, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'b1010, 10, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0000,  9, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0000,  9, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0000,  9, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0000,  9, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0000,  9, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'b1010,  9, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'b1010,  9, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0000,  9, 0, 0, 0, 0, 0));
    // three wrong passwords -> denied each time, lockout on the third
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 9, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 4'b0001, 9, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 9, 0, 1, 0, 0, k == 2));
    end
    for (int k = 0; k < 7; k++) tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 9, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 9, 0, 0, 0, 0, 0));
    // grant after lockout expires
    tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 9, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'b1010, 9, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 8, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 8, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 8, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 8, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 8, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].ex, tbl[i].pv, tbl[i].pass);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].spots, tbl[i].g, tbl[i].d,
              tbl[i].gate, tbl[i].fl, tbl[i].lk);
    end
    exp_spots = 8;

    // password timeout: 16 cycles in WAIT_PASS, then one denied pulse
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("timeout.wait_denied", int'(access_denied), 0);
    end
    tick();
    chk_all("timeout.deny", 8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("timeout.pulse_end", int'(access_denied), 0);

    // reset mid-GRANT aborts the gate and restores the spot count
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b1010);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    chk_all("rstgrant.grant", 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b1010);
    tick();
    chk_all("rstgrant.reset", 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_spots = 10;

    // exit at TOTAL_SPOTS saturates
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    tick();
    chk_all("exit_at_max", 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) do_grant($sformatf("g%0d", i), 1'b0);
    do_grant("coincident", 1'b1);
    chk("coincident.spots5", int'(available_spots), 5);
    for (int i = 5; i < 10; i++) do_grant($sformatf("g%0d", i), 1'b0);
    chk("full.flag", int'(full), 1);

    // full lot: request refused immediately, password then ignored
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    tick();
    chk_all("full.deny", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b1010);
    tick();
    chk("full.deny_pulse_end", int'(access_denied), 0);
    drive(1'b0, 1'b0, 1'b0, 0, 4'b0000);
    tick();
    tick();
    chk_all("full.no_wait_pass", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    tick();
    chk_all("full.exit", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/parking_gate_controller.md
PARKING_GATE_CONTROLLER -- requirements
Module: parking_gate_controller

Interface
REQ-001 Parameter TOTAL_SPOTS, default 10, number of parking spots (1..2**CNT_W-1).
REQ-002 Parameter CNT_W, default 4, width of spot counter.
REQ-003 Parameter PASS_W, default 4, password width.
REQ-004 Parameter PASS_VALUE, default 4'b1010 (zero-extended to PASS_W), correct password.
REQ-005 Parameter MAX_TRIES, default 3, consecutive wrong passwords before lockout.
REQ-006 Parameter PASS_TIMEOUT, default 16, cycles allowed in WAIT_PASS.
REQ-007 Parameter GATE_CYCLES, default 4, cycles gate_open stays high.
REQ-008 Parameter LOCK_CYCLES, default 8, lockout duration in cycles.
REQ-009 One clock; reset is synchronous and active-high.
REQ-010 clk  input  1  clock, all state on rising edge.
REQ-011 reset  input  1  synchronous active-high reset.
REQ-012 car_request  input  1  car at entry requests access (level, sampled in IDLE).
REQ-013 car_exit  input  1  one car leaves per cycle asserted.
REQ-014 pass_valid  input  1  entered_pass is valid this cycle.
REQ-015 entered_pass  input  PASS_W  password from keypad.
REQ-016 available_spots  output  CNT_W  free spots, registered.
REQ-017 access_granted  output  1  one-cycle pulse on grant.
REQ-018 access_denied  output  1  one-cycle pulse on any refusal.
REQ-019 gate_open  output  1  entry gate open.
REQ-020 full  output  1  high when available_spots == 0.
REQ-021 locked  output  1  high while in LOCKOUT.

Function
REQ-022 FSM states: IDLE, WAIT_PASS, CHECK_PASS, GRANT, LOCKOUT; all outputs registered.
REQ-023 IDLE: car_request && !full -> WAIT_PASS; car_request && full -> access_denied pulse next cycle, stay IDLE.
REQ-024 WAIT_PASS: pass_valid -> capture entered_pass, go CHECK_PASS next cycle; timer cleared on entry.
REQ-025 WAIT_PASS: PASS_TIMEOUT cycles without pass_valid -> access_denied pulse, IDLE; fail counter unchanged.
REQ-026 CHECK_PASS (1 cycle): captured == PASS_VALUE and available_spots > 0 -> GRANT, access_granted pulse, spots decrement at same edge, fail counter cleared.
REQ-027 CHECK_PASS: match but available_spots == 0 (exhausted meanwhile) -> access_denied, IDLE, fail counter unchanged.
REQ-028 CHECK_PASS: mismatch -> access_denied, fail counter +1; new count == MAX_TRIES -> LOCKOUT, else IDLE.
REQ-029 GRANT: gate_open high exactly GATE_CYCLES cycles, then IDLE; car_request ignored.
REQ-030 LOCKOUT: locked high exactly LOCK_CYCLES cycles; car_request ignored; exit clears fail counter, goes IDLE.
REQ-031 car_exit increments available_spots in any state if available_spots < TOTAL_SPOTS; ignored at TOTAL_SPOTS.
REQ-032 Grant decrement and car_exit in same cycle: net available_spots unchanged.
REQ-033 available_spots never below 0 nor above TOTAL_SPOTS; no wrap-around.
REQ-034 full derived from next-state spot count, consistent with available_spots each cycle.
REQ-035 Grant latency: request in IDLE at cycle N, pass_valid at N+1 -> access_granted and gate_open rise at N+3.

Reset
REQ-036 reset in any cycle, any state: next state IDLE, available_spots = TOTAL_SPOTS, fail counter, timers 0.
REQ-037 Reset outputs: access_granted 0, access_denied 0, gate_open 0, locked 0, full 0.
REQ-038 Reset overrides simultaneous car_exit, pass_valid, car_request; mid-GRANT or mid-LOCKOUT aborted.

Verification
REQ-039 Defaults; request, pass 4'b1010 -> access_granted one pulse at N+3, gate_open 4 cycles, spots 10->9.
REQ-040 Three wrong passwords (4'b0001) -> three denied pulses, locked 8 cycles, requests ignored, then grant works.
REQ-041 Ten grants -> spots 0, full=1; next request -> access_denied, no WAIT_PASS; one car_exit -> spots 1, full=0.
REQ-042 spots=10, car_exit -> stays 10; grant edge coincident with car_exit at spots 5 -> stays 5.
REQ-043 Request, no pass_valid 16 cycles -> access_denied, IDLE; reset during GRANT -> gate_open 0, spots 10.
